// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for an external N-input gate: drives every input vector,
// compares the gate's response with a reduction-based golden model, and records mismatches.
module gate_sweep_checker #(
  parameter int N_IN  = 2,
  parameter int DWELL = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [N_IN-1:0]  vec;
  logic [CNT_W-1:0] dwell_cnt;
  logic             accept, dwell_end, last_vec, mismatch, err_sat;

  function automatic logic golden(input logic [2:0] f, input logic [N_IN-1:0] v);
    case (f)
      3'd0:    return &v;
      3'd1:    return |v;
      3'd2:    return ^v;
      3'd3:    return ~&v;
      3'd4:    return ~|v;
      3'd5:    return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  assign accept    = start && (op <= 3'd5);
  assign dwell_end = (dwell_cnt == CNT_W'(DWELL - 1));
  assign last_vec  = &vec;
  assign mismatch  = (dut_out != golden(op_r, vec));
  assign err_sat   = &err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dut_in    = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy   = 1'b1;
        dut_in = vec;
        if (dwell_end) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy      = 1'b1;
        dut_in    = vec;
        state_nxt = last_vec ? DONE : DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results persist after DONE; only an accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r           <= '0;
      vec            <= '0;
      dwell_cnt      <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r           <= op;
            vec            <= '0;
            dwell_cnt      <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        DRIVE: begin
          dwell_cnt <= dwell_end ? '0 : dwell_cnt + 1'b1;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (!err_sat) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              first_fail_vec <= vec;
              fail_valid     <= 1'b1;
            end
          end
          // pass must include the final vector's verdict, which lands on this same edge.
          if (last_vec) pass <= !mismatch && (err_count == '0);
          else          vec  <= vec + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three parameterisations driven by a table, corner-case
// sequences, and randomised sweeps scored against a truth-table reference model.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] op;
  logic s0, s1, s2;
  int mode;
  logic [255:0] tt;

  logic [1:0] di0, ffv0; logic [7:0] err0; logic busy0, done0, pass0, fv0, do0;
  logic [2:0] di1, ffv1; logic [7:0] err1; logic busy1, done1, pass1, fv1, do1;
  logic [2:0] di2, ffv2; logic [1:0] err2; logic busy2, done2, pass2, fv2, do2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate-under-test behaviour: 0 AND gate, 1 stuck-at-0, 2 stuck-at-1, 3 arbitrary truth table.
  function automatic logic gut(input int m, input logic [255:0] t, input int n, input int v);
    int c;
    c = $countones(v);
    case (m)
      0:       return (c == n);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return t[v];
    endcase
  endfunction

  function automatic bit gold(input int o, input int n, input int v);
    int c;
    c = $countones(v);
    case (o)
      0:       return c == n;
      1:       return c > 0;
      2:       return (c % 2) == 1;
      3:       return c != n;
      4:       return c == 0;
      default: return (c % 2) == 0;
    endcase
  endfunction

  assign do0 = gut(mode, tt, 2, int'(di0));
  assign do1 = gut(mode, tt, 3, int'(di1));
  assign do2 = gut(mode, tt, 3, int'(di2));

  gate_sweep_checker #(.N_IN(2), .DWELL(1), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .op(op), .dut_out(do0), .dut_in(di0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
    .first_fail_vec(ffv0));
  gate_sweep_checker #(.N_IN(3), .DWELL(3), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .op(op), .dut_out(do1), .dut_in(di1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .first_fail_vec(ffv1));
  gate_sweep_checker #(.N_IN(3), .DWELL(1), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .op(op), .dut_out(do2), .dut_in(di2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2),
    .first_fail_vec(ffv2));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       s0 = v;
      1:       s1 = v;
      default: s2 = v;
    endcase
  endtask

  task automatic snap(input int inst, output int di, output bit b, output bit d,
                      output bit p, output bit fv, output int err, output int ffv);
    case (inst)
      0: begin di = int'(di0); b = busy0; d = done0; p = pass0; fv = fv0; err = int'(err0); ffv = int'(ffv0); end
      1: begin di = int'(di1); b = busy1; d = done1; p = pass1; fv = fv1; err = int'(err1); ffv = int'(ffv1); end
      default: begin di = int'(di2); b = busy2; d = done2; p = pass2; fv = fv2; err = int'(err2); ffv = int'(ffv2); end
    endcase
  endtask

  // Starts a sweep (start accepted at "edge 0"), counts edges until done is seen,
  // and confirms dut_in steps through vectors with DWELL+1 cycles each.
  task automatic run_sweep(input int inst, input int o, output int edges, output int err,
                           output int ffv, output bit fv, output bit pas, output bit seq_ok);
    int dw, di, e, f;
    bit b, d, p, v;
    dw = (inst == 1) ? 3 : 1;
    @(negedge clk);
    op = 3'(o);
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    edges = 0;
    seq_ok = 1'b1;
    snap(inst, di, b, d, p, v, e, f);
    while (!d && edges < 300) begin
      if (!b || di != edges / (dw + 1)) seq_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
      snap(inst, di, b, d, p, v, e, f);
    end
    err = e; ffv = f; fv = v; pas = p;
    @(posedge clk); #1;
    snap(inst, di, b, d, p, v, e, f);
    if (d || b || di != 0) seq_ok = 1'b0;
  endtask

  typedef struct {
    int inst; int op; int mode;
    int exp_err; int exp_ffv; bit exp_fv; bit exp_pass; int exp_edges;
  } vec_t;

  vec_t tbl[5];
  int edges, err, ffv, di, e2, f2, cnt, first, n, errw, dw, emax;
  bit fv, pas, sok, b, d, p, v, seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 1'b0, 1'b1, 8};   // AND gate, AND sweep
    tbl[1] = '{0, 1, 0, 2, 1, 1'b1, 1'b0, 8};   // AND gate vs OR golden
    tbl[2] = '{0, 2, 2, 2, 0, 1'b1, 1'b0, 8};   // stuck-1 vs XOR
    tbl[3] = '{1, 5, 1, 4, 0, 1'b1, 1'b0, 32};  // N=3 DWELL=3, XNOR vs stuck-0
    tbl[4] = '{2, 0, 2, 3, 0, 1'b1, 1'b0, 16};  // ERR_W=2 saturation

    rst_n = 1'b0; s0 = 0; s1 = 0; s2 = 0; op = 3'd0; mode = 0; tt = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      snap(i, di, b, d, p, v, e2, f2);
      check($sformatf("reset_state_u%0d", i), int'({b, d, p, v}) + di + e2 + f2, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep(tbl[i].inst, tbl[i].op, edges, err, ffv, fv, pas, sok);
      check($sformatf("tbl%0d_edges", i), edges, tbl[i].exp_edges);
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("tbl%0d_ffv", i), ffv, tbl[i].exp_ffv);
      check($sformatf("tbl%0d_fv", i), int'(fv), int'(tbl[i].exp_fv));
      check($sformatf("tbl%0d_pass", i), int'(pas), int'(tbl[i].exp_pass));
      check($sformatf("tbl%0d_seq", i), int'(sok), 1);
    end

    // Re-pulsed start and op change mid-sweep must not disturb the sweep.
    mode = 0;
    fork
      run_sweep(0, 0, edges, err, ffv, fv, pas, sok);
      begin
        repeat (3) @(posedge clk);
        #2; s0 = 1'b1; op = 3'd6;
        repeat (2) @(posedge clk);
        #2; s0 = 1'b0;
      end
    join
    check("restart_edges", edges, 8);
    check("restart_pass", int'(pas), 1);
    check("restart_err", err, 0);
    check("restart_seq", int'(sok), 1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy0 || done0) seen = 1'b1;
    end
    check("restart_no_second_sweep", int'(seen), 0);

    // Reserved op leaves previous results untouched.
    mode = 0;
    run_sweep(0, 1, edges, err, ffv, fv, pas, sok);
    for (int r = 6; r <= 7; r++) begin
      @(negedge clk); op = 3'(r); s0 = 1'b1;
      seen = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (busy0 || done0) seen = 1'b1;
      end
      @(negedge clk); s0 = 1'b0;
      check($sformatf("op%0d_busy", r), int'(seen), 0);
      check($sformatf("op%0d_held", r), int'({pass0, fv0}) * 1000 + int'(err0) * 10 + int'(ffv0), 1000 + 20 + 1);
    end

    // Start held continuously: one IDLE cycle after DONE, then a new sweep.
    @(negedge clk); op = 3'd0; s0 = 1'b1;
    cnt = 0;
    while (!done0 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("held_first_done", int'(done0), 1);
    @(posedge clk); #1;
    check("held_idle_gap", int'({busy0, done0}), 0);
    @(posedge clk); #1;
    check("held_restart_busy", int'(busy0), 1);
    @(negedge clk); s0 = 1'b0;
    cnt = 0;
    while (!done0 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("held_second_done", int'(done0), 1);
    @(posedge clk); #1;

    // Asynchronous reset during DRIVE of vector 2.
    @(negedge clk); op = 3'd1; s0 = 1'b1;
    @(posedge clk); #1; s0 = 1'b0;
    cnt = 0;
    while (!(busy0 && di0 == 2'd2) && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("async_pre_err", int'(err0), 1);
    #3; rst_n = 1'b0;
    #1;
    check("async_outputs_zero",
          int'({busy0, done0, pass0, fv0}) + int'(di0) + int'(err0) + int'(ffv0), 0);
    @(negedge clk); rst_n = 1'b1;
    mode = 0;
    run_sweep(0, 0, edges, err, ffv, fv, pas, sok);
    check("post_reset_pass", int'(pas), 1);
    check("post_reset_edges", edges, 8);

    // Randomised sweeps against the truth-table model.
    for (int k = 0; k < 12; k++) begin
      int inst, o;
      inst = $urandom_range(0, 2);
      o = $urandom_range(0, 5);
      mode = $urandom_range(0, 3);
      tt = 256'($urandom);
      n = (inst == 0) ? 2 : 3;
      dw = (inst == 1) ? 3 : 1;
      errw = (inst == 2) ? 2 : 8;
      emax = (1 << errw) - 1;
      cnt = 0; first = -1;
      for (int vv = 0; vv < (1 << n); vv++) begin
        if (gut(mode, tt, n, vv) != gold(o, n, vv)) begin
          cnt++;
          if (first < 0) first = vv;
        end
      end
      run_sweep(inst, o, edges, err, ffv, fv, pas, sok);
      check($sformatf("rnd%0d_err", k), err, (cnt > emax) ? emax : cnt);
      check($sformatf("rnd%0d_ffv", k), ffv, (first < 0) ? 0 : first);
      check($sformatf("rnd%0d_fv", k), int'(fv), int'(first >= 0));
      check($sformatf("rnd%0d_pass", k), int'(pas), int'(cnt == 0));
      check($sformatf("rnd%0d_edges", k), edges, (1 << n) * (dw + 1));
      check($sformatf("rnd%0d_seq", k), int'(sok), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- In-hardware successor to the directed 2-input gate bench.
- Drives every input combination of an external N-input gate-under-test and compares each response with an internal golden model.
- Counts mismatches and captures the first failing vector.
- Sits beside the gate-under-test on the assignment boards; `start`/`done` handshake to the host.

Parameters:
- N_IN, 2, gate input count; legal 2..8; sweep length 2^N_IN vectors.
- DWELL, 1, cycles each vector is held before sampling; legal >=1.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request, sampled only in IDLE.
- op  input  3  gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6-7 reserved.
- dut_out  input  1  response from the gate-under-test.
- dut_in  output  N_IN  vector driven to the gate-under-test.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the completed sweep had zero mismatches.
- err_count  output  ERR_W  mismatch count, saturating.
- fail_valid  output  1  first_fail_vec holds a captured vector.
- first_fail_vec  output  N_IN  vector of the first mismatch.

Behaviour:
- Reset is asynchronous and active-low.
  - Assertion forces IDLE immediately, including mid-sweep.
  - All outputs go to 0 on reset.
- Golden model: reductions over all N_IN bits of the vector. AND=&v, OR=|v, XOR=^v, NAND=~&v, NOR=~|v, XNOR=~^v.
- op is latched when start is accepted and held for the sweep; later changes to op are ignored.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE
  - dut_in=0, busy=0.
  - start=1 with op<=5: latch op, clear vec, err_count, fail_valid, first_fail_vec and pass; go to DRIVE.
  - start=1 with op 6 or 7: ignored, stay in IDLE, no output changes.
- DRIVE
  - dut_in=vec.
  - Dwell counter runs DWELL cycles, then SAMPLE.
- SAMPLE
  - dut_in=vec, held for 1 cycle.
  - At the exiting edge, compare dut_out with golden(op, vec).
  - On mismatch: err_count+1, saturating at 2^ERR_W-1.
  - On the first mismatch only: first_fail_vec=vec, fail_valid=1.
  - If vec==2^N_IN-1, go to DONE. Otherwise vec+1 and back to DRIVE. vec never wraps inside a sweep.
- DONE
  - done=1 for exactly one cycle; pass=(err_count==0); dut_in=0.
  - Next state is IDLE.
- Timing: start accepted at edge 0 gives each vector DWELL+1 cycles. done is high during the cycle following edge 2^N_IN*(DWELL+1).
- pass, err_count, fail_valid and first_fail_vec are registered and held after DONE until the next accepted start.
- start while busy or in DONE is ignored; there is no queued request.
- start held high continuously starts a new sweep on the first IDLE cycle after DONE.
- dut_out is sampled only at the SAMPLE-exit edge; glitches during DRIVE have no effect.

Test Plan:
1. N_IN=2, DWELL=1, bench models DUT as AND of dut_in, op=0, start pulse at edge 0.
   - dut_in steps 00,01,10,11, each held 2 cycles.
   - done high after edge 8; pass=1, err_count=0, fail_valid=0.
2. Same DUT, op=1 (OR).
   - Mismatches at vectors 01 and 10.
   - err_count=2, first_fail_vec=2'b01, fail_valid=1, pass=0.
3. Start held during a sweep and re-pulsed mid-sweep.
   - Sweep unaffected; done pulses once.
   - Separately, start with op=6: busy stays 0 and outputs are unchanged.
4. rst_n low asynchronously while vec=2 in DRIVE.
   - All outputs 0 immediately, with no clock edge needed.
   - After release, a new op=0 sweep completes with pass=1.
5. N_IN=3, DWELL=3, op=5 (XNOR), DUT stuck-at-0.
   - Fails at vectors 0,3,5,6: err_count=4, first_fail_vec=3'b000.
   - done after edge 32.
6. ERR_W=2, N_IN=3, op=0 (AND), DUT stuck-at-1.
   - 7 mismatches; err_count saturates at 3.
   - first_fail_vec=0, pass=0.
